// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types used by the ROB, register file and write-back arbiter.
package wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  regIdx;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } wb_req_t;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_SLOT1,
        WIN_FIFO,
        WIN_LOAD
    } winner_e;

    // A request only touches the register file when it targets a non-zero register.
    function automatic logic writesReg(input wb_req_t req);
        return req.valid && (req.regIdx != '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-result buffer for the write-back arbiter: in-order FIFO with flush and a
// registered almost-full flag (count >= DEPTH-1 after this cycle's update).
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic                   push,
    input  wb_req_t                pushData,
    input  logic                   pop,
    input  logic                   flush,
    output wb_req_t                head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   almostFull
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   rdPtr;
    logic [PW-1:0]   wrPtr;
    logic [CW-1:0]   nextCount;
    logic            doPush;
    logic            doPop;

    assign full   = (count == CW'(DEPTH));
    assign head   = mem[rdPtr];
    assign doPush = push && !full && !flush;
    assign doPop  = pop && (count != '0) && !flush;

    always_comb begin
        nextCount = count;
        if (flush) begin
            nextCount = '0;
        end else if (doPush && !doPop) begin
            nextCount = count + 1'b1;
        end else if (!doPush && doPop) begin
            nextCount = count - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            almostFull <= 1'b0;
        end else begin
            count      <= nextCount;
            almostFull <= (nextCount >= CW'(DEPTH - 1));
            if (flush) begin
                rdPtr <= '0;
                wrPtr <= '0;
            end else begin
                if (doPush) wrPtr <= wrPtr + 1'b1;
                if (doPop)  rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: port 1 carries ROB slot 0, port 2 is shared by
// ROB slot 1, buffered load results and direct load returns.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 2
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              c0_valid,
    input  logic [REG_W-1:0]  c0_reg,
    input  logic [DATA_W-1:0] c0_data,
    input  logic [TAG_W-1:0]  c0_tag,
    input  logic              c1_valid,
    input  logic [REG_W-1:0]  c1_reg,
    input  logic [DATA_W-1:0] c1_data,
    input  logic [TAG_W-1:0]  c1_tag,
    output logic              c1_ready,
    input  logic              m_valid,
    input  logic [REG_W-1:0]  m_reg,
    input  logic [DATA_W-1:0] m_data,
    input  logic [TAG_W-1:0]  m_tag,
    output logic              m_full,
    input  logic              flush,
    output logic              we1,
    output logic [REG_W-1:0]  wa1,
    output logic [DATA_W-1:0] wd1,
    output logic [TAG_W-1:0]  wt1,
    output logic              we2,
    output logic [REG_W-1:0]  wa2,
    output logic [DATA_W-1:0] wd2,
    output logic [TAG_W-1:0]  wt2
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    wb_req_t                      c0Req;
    wb_req_t                      c1Req;
    wb_req_t                      loadReq;
    wb_req_t                      fifoHead;
    wb_req_t                      port2Sel;
    logic [$clog2(FIFO_DEPTH):0]  fifoCount;
    logic                         fifoFull;
    logic                         fifoEmpty;
    logic                         fifoPush;
    logic                         fifoPop;
    logic [SW-1:0]                starveCnt;
    logic [SW-1:0]                starveNext;
    logic                         starved;
    winner_e                      winner;

    assign c0Req   = '{valid: c0_valid, regIdx: c0_reg, data: c0_data, tag: c0_tag};
    assign c1Req   = '{valid: c1_valid, regIdx: c1_reg, data: c1_data, tag: c1_tag};
    assign loadReq = '{valid: m_valid,  regIdx: m_reg,  data: m_data,  tag: m_tag};

    assign fifoEmpty = (fifoCount == '0);
    assign starved   = (starveCnt >= SW'(STARVE_MAX));

    // During flush buffered and same-cycle loads are dead, so only slot 1 may compete.
    always_comb begin
        winner = WIN_NONE;
        if (c1_valid && starved) begin
            winner = WIN_SLOT1;
        end else if (!flush && !fifoEmpty) begin
            winner = WIN_FIFO;
        end else if (!flush && m_valid) begin
            winner = WIN_LOAD;
        end else if (c1_valid) begin
            winner = WIN_SLOT1;
        end
    end

    always_comb begin
        port2Sel = '0;
        case (winner)
            WIN_SLOT1: port2Sel = c1Req;
            WIN_FIFO:  port2Sel = fifoHead;
            WIN_LOAD:  port2Sel = loadReq;
            default:   port2Sel = '0;
        endcase
    end

    assign c1_ready = (winner == WIN_SLOT1);
    assign fifoPop  = (winner == WIN_FIFO);
    assign fifoPush = m_valid && !flush && (winner != WIN_LOAD) && !fifoFull;

    always_comb begin
        starveNext = starveCnt;
        if (flush || !c1_valid || c1_ready) begin
            starveNext = '0;
        end else if (!starved) begin
            starveNext = starveCnt + 1'b1;
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) loadFifo (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .push       (fifoPush),
        .pushData   (loadReq),
        .pop        (fifoPop),
        .flush      (flush),
        .head       (fifoHead),
        .count      (fifoCount),
        .full       (fifoFull),
        .almostFull (m_full)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            starveCnt <= '0;
            we1       <= 1'b0;
            wa1       <= '0;
            wd1       <= '0;
            wt1       <= '0;
            we2       <= 1'b0;
            wa2       <= '0;
            wd2       <= '0;
            wt2       <= '0;
        end else begin
            starveCnt <= starveNext;
            we1       <= writesReg(c0Req);
            if (c0_valid) begin
                wa1 <= c0_reg;
                wd1 <= c0_data;
                wt1 <= c0_tag;
            end
            we2 <= (winner != WIN_NONE) && writesReg(port2Sel);
            if (winner != WIN_NONE) begin
                wa2 <= port2Sel.regIdx;
                wd2 <= port2Sel.data;
                wt2 <= port2Sel.tag;
            end
        end
    end

    // A load the cache issued while the buffer was already full is lost.
    assert property (@(posedge CLK) disable iff (!reset_n)
        !(m_valid && !flush && (winner != WIN_LOAD) && fifoFull));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: expected writes are queued per port and
// an independent monitor pops and compares whenever we1/we2 fires.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic              CLK;
    logic              reset_n;
    wb_req_t           c0;
    wb_req_t           c1;
    wb_req_t           ld;
    logic              flushIn;
    logic              c1_ready;
    logic              m_full;
    logic              we1;
    logic [REG_W-1:0]  wa1;
    logic [DATA_W-1:0] wd1;
    logic [TAG_W-1:0]  wt1;
    logic              we2;
    logic [REG_W-1:0]  wa2;
    logic [DATA_W-1:0] wd2;
    logic [TAG_W-1:0]  wt2;

    int checks = 0;
    int errors = 0;

    logic [40:0] q1[$];
    logic [40:0] q2[$];

    wb_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (2)
    ) dut (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .c0_valid (c0.valid),
        .c0_reg   (c0.regIdx),
        .c0_data  (c0.data),
        .c0_tag   (c0.tag),
        .c1_valid (c1.valid),
        .c1_reg   (c1.regIdx),
        .c1_data  (c1.data),
        .c1_tag   (c1.tag),
        .c1_ready (c1_ready),
        .m_valid  (ld.valid),
        .m_reg    (ld.regIdx),
        .m_data   (ld.data),
        .m_tag    (ld.tag),
        .m_full   (m_full),
        .flush    (flushIn),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .wt1      (wt1),
        .we2      (we2),
        .wa2      (wa2),
        .wd2      (wd2),
        .wt2      (wt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic wb_req_t mk(input logic [4:0] r, input logic [31:0] d, input logic [3:0] t);
        wb_req_t x;
        x.valid  = 1'b1;
        x.regIdx = r;
        x.data   = d;
        x.tag    = t;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic exp1(input wb_req_t r);
        q1.push_back({r.regIdx, r.data, r.tag});
    endtask

    task automatic exp2(input wb_req_t r);
        q2.push_back({r.regIdx, r.data, r.tag});
    endtask

    // Drive one cycle of requests, check c1_ready, then advance past the edge.
    task automatic cyc(input wb_req_t a, input wb_req_t b, input wb_req_t m,
                       input logic fl, input logic expRdy);
        c0 = a;
        c1 = b;
        ld = m;
        flushIn = fl;
        #1 chk("c1_ready", c1_ready, expRdy);
        @(posedge CLK);
        #1;
        c0 = '0;
        c1 = '0;
        ld = '0;
        flushIn = 1'b0;
    endtask

    always @(negedge CLK) begin
        logic [40:0] e;
        if (reset_n) begin
            if (we1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL port1_unexpected actual=%0h/%0h/%0h expected=none", wa1, wd1, wt1);
                end else begin
                    e = q1.pop_front();
                    if ({wa1, wd1, wt1} !== e) begin
                        errors++;
                        $display("FAIL port1_write actual=%0h expected=%0h", {wa1, wd1, wt1}, e);
                    end
                end
            end
            if (we2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL port2_unexpected actual=%0h/%0h/%0h expected=none", wa2, wd2, wt2);
                end else begin
                    e = q2.pop_front();
                    if ({wa2, wd2, wt2} !== e) begin
                        errors++;
                        $display("FAIL port2_write actual=%0h expected=%0h", {wa2, wd2, wt2}, e);
                    end
                end
            end
        end
    end

    initial begin
        wb_req_t n;
        wb_req_t xr, yr, zr, wr;
        wb_req_t l1, l2, l3, l4, l5, l6, l7, l8, l9;
        n = '0;
        c0 = '0;
        c1 = '0;
        ld = '0;
        flushIn = 1'b0;
        reset_n = 1'b0;

        #3;
        chk("rst_we", {we1, we2}, 0);
        chk("rst_wa", {wa1, wa2}, 0);
        chk("rst_wd", {wd1, wd2}, 0);
        chk("rst_wt", {wt1, wt2}, 0);
        chk("rst_mfull", m_full, 0);
        @(negedge CLK);
        reset_n = 1'b1;
        @(posedge CLK);
        #1;

        // Both commit slots, no load.
        exp1(mk(3, 32'h11, 1));
        exp2(mk(4, 32'h22, 2));
        cyc(mk(3, 32'h11, 1), mk(4, 32'h22, 2), n, 0, 1);
        chk("dual_we", {we1, we2}, 2'b11);
        chk("dual_wa1", wa1, 3);
        chk("dual_wa2", wa2, 4);
        chk("dual_wd2", wd2, 32'h22);
        cyc(n, n, n, 0, 0);

        // Loads beat slot 1 until it has starved for two cycles.
        wr = mk(6, 32'h66, 4);
        exp2(mk(5, 32'hAA, 3));
        cyc(n, wr, mk(5, 32'hAA, 3), 0, 0);
        chk("load_wins_wa2", wa2, 5);
        exp2(mk(7, 32'hB7, 5));
        cyc(n, wr, mk(7, 32'hB7, 5), 0, 0);
        exp2(wr);
        cyc(n, wr, mk(8, 32'hB8, 6), 0, 1);
        chk("starve_win_wa2", wa2, 6);
        exp2(mk(8, 32'hB8, 6));
        cyc(n, n, n, 0, 0);
        cyc(n, n, n, 0, 0);

        // Continuous loads with slot 1 always pending: buffer fills, order kept.
        xr = mk(13, 32'hC1, 1);
        yr = mk(0,  32'hC2, 2);
        zr = mk(14, 32'hC3, 3);
        l1 = mk(17, 32'h101, 1);
        l2 = mk(18, 32'h102, 2);
        l3 = mk(19, 32'h103, 3);
        l4 = mk(20, 32'h104, 4);
        l5 = mk(0,  32'h105, 5);
        l6 = mk(22, 32'h106, 6);
        l7 = mk(23, 32'h107, 7);
        l8 = mk(24, 32'h108, 8);
        l9 = mk(25, 32'h109, 9);
        exp2(l1); cyc(n, xr, l1, 0, 0);
        exp2(l2); cyc(n, xr, l2, 0, 0);
        exp2(xr); cyc(n, xr, l3, 0, 1);
        exp2(l3); cyc(n, yr, l4, 0, 0);
        exp2(l4); cyc(n, yr, l5, 0, 0);
        cyc(n, yr, l6, 0, 1);
        cyc(n, zr, l7, 0, 0);
        exp2(l6); cyc(n, zr, l8, 0, 0);
        chk("mfull_at_2", m_full, 0);
        exp2(zr); cyc(n, zr, l9, 0, 1);
        chk("mfull_at_3", m_full, 1);
        exp2(l7); cyc(n, n, n, 0, 0);
        chk("mfull_drain", m_full, 0);

        // Flush with two buffered loads and a same-cycle load.
        exp1(mk(9, 32'h99, 7));
        exp2(mk(10, 32'hA1, 8));
        cyc(mk(9, 32'h99, 7), mk(10, 32'hA1, 8), mk(11, 32'hEE, 9), 1, 1);
        chk("flush_we2_c1", {we1, we2}, 2'b11);
        cyc(n, n, n, 0, 0);
        chk("flush_mfull", m_full, 0);
        cyc(n, n, n, 0, 0);

        // Writes to register 0 are consumed silently.
        cyc(mk(0, 32'h55, 1), n, mk(0, 32'h66, 2), 0, 0);
        chk("r0_we", {we1, we2}, 0);
        chk("r0_wd1", wd1, 32'h55);
        chk("r0_wa2", wa2, 0);
        cyc(n, n, n, 0, 0);

        // Reset asserted while a load is still buffered.
        wr = mk(15, 32'hD0, 4);
        exp2(mk(20, 32'hDA, 5)); cyc(n, wr, mk(20, 32'hDA, 5), 0, 0);
        exp2(mk(21, 32'hDB, 6)); cyc(n, wr, mk(21, 32'hDB, 6), 0, 0);
        exp2(wr);                cyc(n, wr, mk(22, 32'hE1, 7), 0, 1);
        exp2(mk(22, 32'hE1, 7)); cyc(n, n, mk(23, 32'hE2, 8), 0, 0);
        @(negedge CLK);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_we", {we1, we2}, 0);
        chk("midrst_wa2", wa2, 0);
        chk("midrst_mfull", m_full, 0);
        @(posedge CLK);
        #2 reset_n = 1'b1;
        @(posedge CLK);
        #1;
        cyc(n, n, n, 0, 0);
        cyc(n, n, n, 0, 0);
        cyc(n, n, n, 0, 0);
        exp1(mk(12, 32'h12C, 3));
        cyc(mk(12, 32'h12C, 3), n, n, 0, 0);
        cyc(n, n, n, 0, 0);
        cyc(n, n, n, 0, 0);

        chk("port1_pending", q1.size(), 0);
        chk("port2_pending", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
